// File: rtl/ca_distributor_mc.sv
// CA beat distributor: routes host CA beats (with even parity) into per-subchannel FWFT FIFOs.
// Broadcast pushes are atomic: a beat is accepted only when every targeted FIFO has room.
module ca_distributor_mc #(
  parameter int CA_WIDTH   = 14,
  parameter int NUM_SC     = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int RANK_BITS  = 2,
  localparam int SCW   = (NUM_SC > 1) ? $clog2(NUM_SC) : 1,
  localparam int CW    = $clog2(FIFO_DEPTH) + 1,
  localparam int NRANK = 2 ** RANK_BITS
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic                       flush,
  input  logic [1:0]                 routing_mode,
  input  logic [SCW-1:0]             sc_select,
  input  logic [NRANK*SCW-1:0]       rank_map,
  input  logic [CA_WIDTH-1:0]        ca_in,
  input  logic [RANK_BITS-1:0]       ca_rank_in,
  input  logic                       ca_valid_in,
  output logic                       ca_ready_out,
  output logic [NUM_SC*CA_WIDTH-1:0] ca_out,
  output logic [NUM_SC-1:0]          ca_par_out,
  output logic [NUM_SC-1:0]          ca_valid_out,
  input  logic [NUM_SC-1:0]          ca_ready_in,
  output logic [NUM_SC*CW-1:0]       fifo_level,
  output logic [31:0]                pkt_count,
  output logic [31:0]                err_count
);

  localparam int AW = CW - 1;

  // entry = {beat, parity}
  logic [CA_WIDTH:0]  mem [NUM_SC][FIFO_DEPTH];
  logic [CW-1:0]      wptr [NUM_SC];
  logic [CW-1:0]      rptr [NUM_SC];
  logic [NUM_SC-1:0]  tgt;
  logic [NUM_SC-1:0]  full;
  logic [NUM_SC-1:0]  empty;
  logic [NUM_SC-1:0]  push;
  logic [NUM_SC-1:0]  pop;
  logic [SCW-1:0]     idx;
  logic               idx_used;
  logic               accept;
  logic               err_inc;

  always_comb begin
    idx      = '0;
    idx_used = 1'b0;
    tgt      = '0;
    case (routing_mode)
      2'b00: tgt = '1;
      2'b01: begin
        idx      = sc_select;
        idx_used = 1'b1;
      end
      2'b10: begin
        idx      = rank_map[int'(ca_rank_in)*SCW +: SCW];
        idx_used = 1'b1;
      end
      default: ;
    endcase
    // an index >= NUM_SC matches no subchannel, leaving tgt empty
    if (idx_used) begin
      for (int s = 0; s < NUM_SC; s++) begin
        tgt[s] = (idx == SCW'(s));
      end
    end
  end

  always_comb begin
    full  = '0;
    empty = '0;
    for (int s = 0; s < NUM_SC; s++) begin
      full[s]  = (wptr[s][AW] != rptr[s][AW]) && (wptr[s][AW-1:0] == rptr[s][AW-1:0]);
      empty[s] = (wptr[s] == rptr[s]);
    end
  end

  assign ca_ready_out = rst_n & enable & ~flush & (routing_mode != 2'b11) & (&(~tgt | ~full));
  assign accept       = ca_valid_in & ca_ready_out;
  assign push         = {NUM_SC{accept}} & tgt;
  assign pop          = ~empty & ca_ready_in;
  assign err_inc      = (accept && (tgt == '0)) ||
                        (ca_valid_in && enable && (routing_mode == 2'b11));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SC; s++) begin
        wptr[s] <= '0;
        rptr[s] <= '0;
      end
    end else begin
      for (int s = 0; s < NUM_SC; s++) begin
        if (flush) begin
          wptr[s] <= '0;
          rptr[s] <= '0;
        end else begin
          if (push[s]) wptr[s] <= wptr[s] + 1'b1;
          if (pop[s])  rptr[s] <= rptr[s] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int s = 0; s < NUM_SC; s++) begin
      if (push[s]) mem[s][wptr[s][AW-1:0]] <= {ca_in, ^ca_in};
    end
  end

  // outputs are gated by occupancy so stale storage never leaks out after reset or flush
  always_comb begin
    ca_out     = '0;
    ca_par_out = '0;
    fifo_level = '0;
    for (int s = 0; s < NUM_SC; s++) begin
      if (!empty[s]) begin
        ca_out[s*CA_WIDTH +: CA_WIDTH] = mem[s][rptr[s][AW-1:0]][CA_WIDTH:1];
        ca_par_out[s]                  = mem[s][rptr[s][AW-1:0]][0];
      end
      fifo_level[s*CW +: CW] = wptr[s] - rptr[s];
    end
  end

  assign ca_valid_out = ~empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_count <= '0;
      err_count <= '0;
    end else begin
      if (accept && (pkt_count != 32'hFFFF_FFFF))  pkt_count <= pkt_count + 32'd1;
      if (err_inc && (err_count != 32'hFFFF_FFFF)) err_count <= err_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_ca_distributor_mc.sv
// Scoreboard bench for ca_distributor_mc, built with three subchannels so that
// a rank-map entry can point past the last subchannel.
module tb_ca_distributor_mc;

  logic        clk = 1'b0;
  logic        rst_n, enable, flush;
  logic [1:0]  routing_mode, sc_select, ca_rank_in;
  logic [7:0]  rank_map;
  logic [13:0] ca_in;
  logic        ca_valid_in, ca_ready_out;
  logic [41:0] ca_out;
  logic [2:0]  ca_par_out, ca_valid_out, ca_ready_in;
  logic [8:0]  fifo_level;
  logic [31:0] pkt_count, err_count;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_pkt = 0;
  int exp_err = 0;
  logic [14:0] q0[$], q1[$], q2[$];
  logic [14:0] mon_act, mon_exp;
  logic        mon_have;

  ca_distributor_mc #(.CA_WIDTH(14), .NUM_SC(3), .FIFO_DEPTH(4), .RANK_BITS(2)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .flush(flush),
    .routing_mode(routing_mode), .sc_select(sc_select), .rank_map(rank_map),
    .ca_in(ca_in), .ca_rank_in(ca_rank_in), .ca_valid_in(ca_valid_in),
    .ca_ready_out(ca_ready_out), .ca_out(ca_out), .ca_par_out(ca_par_out),
    .ca_valid_out(ca_valid_out), .ca_ready_in(ca_ready_in), .fifo_level(fifo_level),
    .pkt_count(pkt_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] lvl(input int s);
    return fifo_level[s*3 +: 3];
  endfunction

  function automatic void exp_push(input int s, input logic [13:0] d);
    case (s)
      0: q0.push_back({d, ^d});
      1: q1.push_back({d, ^d});
      default: q2.push_back({d, ^d});
    endcase
  endfunction

  // monitor: a beat presented with ready high leaves at the next edge
  always @(negedge clk) begin
    if (rst_n && !flush) begin
      for (int s = 0; s < 3; s++) begin
        if (ca_valid_out[s] && ca_ready_in[s]) begin
          mon_act  = {ca_out[s*14 +: 14], ca_par_out[s]};
          mon_have = 1'b0;
          mon_exp  = '0;
          case (s)
            0: if (q0.size() > 0) begin mon_exp = q0.pop_front(); mon_have = 1'b1; end
            1: if (q1.size() > 0) begin mon_exp = q1.pop_front(); mon_have = 1'b1; end
            default: if (q2.size() > 0) begin mon_exp = q2.pop_front(); mon_have = 1'b1; end
          endcase
          if (!mon_have) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sc%0d_unexpected: got %0h expected nothing", s, mon_act);
          end else begin
            chk($sformatf("sc%0d_data", s), mon_act, mon_exp);
          end
        end
      end
    end
  end

  // one-cycle beat; returns at posedge+1 with valid dropped
  task automatic beat(input logic [1:0] mode, input logic [1:0] sel, input logic [1:0] rank,
                      input logic [13:0] d, input logic exp_acc, input logic [2:0] mask,
                      input string name);
    routing_mode = mode;
    sc_select    = sel;
    ca_rank_in   = rank;
    ca_in        = d;
    ca_valid_in  = 1'b1;
    @(negedge clk);
    chk({name, "_ready"}, ca_ready_out, exp_acc);
    if (exp_acc) begin
      exp_pkt++;
      if (mask == 3'b000) exp_err++;
      for (int s = 0; s < 3; s++) if (mask[s]) exp_push(s, d);
    end
    @(posedge clk);
    #1;
    ca_valid_in = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [13:0] d;
    rst_n = 1'b0; enable = 1'b1; flush = 1'b0; routing_mode = 2'b00; sc_select = '0;
    rank_map = 8'b11_00_01_00; ca_in = '0; ca_rank_in = '0; ca_valid_in = 1'b0;
    ca_ready_in = 3'b000;
    #12;
    chk("rst_ready", ca_ready_out, 1'b0);
    chk("rst_valid", ca_valid_out, 3'b000);
    chk("rst_out", ca_out, 42'd0);
    chk("rst_par", ca_par_out, 3'b000);
    chk("rst_level", fifo_level, 9'd0);
    chk("rst_pkt", pkt_count, 32'd0);
    chk("rst_err", err_count, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // T1: broadcast, 0x1A5B has eight ones so even parity is 0
    ca_ready_in = 3'b111;
    beat(2'b00, 2'd0, 2'd0, 14'h1A5B, 1'b1, 3'b111, "t1");
    chk("t1_out0", ca_out[13:0], 14'h1A5B);
    chk("t1_out1", ca_out[27:14], 14'h1A5B);
    chk("t1_out2", ca_out[41:28], 14'h1A5B);
    chk("t1_par", ca_par_out, 3'b000);
    chk("t1_valid", ca_valid_out, 3'b111);
    chk("t1_pkt", pkt_count, 32'd1);
    cycles(1);
    chk("t1_drained", ca_valid_out, 3'b000);

    // T2: unicast to SC1 with sink stalled; fifth beat refused
    ca_ready_in = 3'b000;
    beat(2'b01, 2'd1, 2'd0, 14'h0101, 1'b1, 3'b010, "t2_b1");
    beat(2'b01, 2'd1, 2'd0, 14'h0202, 1'b1, 3'b010, "t2_b2");
    beat(2'b01, 2'd1, 2'd0, 14'h0303, 1'b1, 3'b010, "t2_b3");
    beat(2'b01, 2'd1, 2'd0, 14'h0404, 1'b1, 3'b010, "t2_b4");
    beat(2'b01, 2'd1, 2'd0, 14'h0505, 1'b0, 3'b000, "t2_b5");
    chk("t2_level1", lvl(1), 3'd4);
    chk("t2_valid", ca_valid_out, 3'b010);
    chk("t2_pkt", pkt_count, 32'd5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_stall_data", ca_out[27:14], 14'h0101);
      chk("t6_stall_par", ca_par_out[1], 1'b0);
    end
    @(posedge clk); #1;
    ca_ready_in = 3'b010;
    cycles(5);
    ca_ready_in = 3'b000;
    chk("t2_empty", lvl(1), 3'd0);

    // T3: broadcast blocked by full SC1, released by a single pop
    beat(2'b01, 2'd1, 2'd0, 14'h0A01, 1'b1, 3'b010, "t3_f1");
    beat(2'b01, 2'd1, 2'd0, 14'h0A02, 1'b1, 3'b010, "t3_f2");
    beat(2'b01, 2'd1, 2'd0, 14'h0A03, 1'b1, 3'b010, "t3_f3");
    beat(2'b01, 2'd1, 2'd0, 14'h0A04, 1'b1, 3'b010, "t3_f4");
    routing_mode = 2'b00; ca_in = 14'h1234; ca_valid_in = 1'b1;
    @(negedge clk);
    chk("t3_blocked", ca_ready_out, 1'b0);
    @(posedge clk); #1;
    chk("t3_no_push_sc0", lvl(0), 3'd0);
    ca_ready_in = 3'b010;
    @(negedge clk);
    chk("t3_no_passthru", ca_ready_out, 1'b0);
    @(posedge clk); #1;
    ca_ready_in = 3'b000;
    @(negedge clk);
    chk("t3_release", ca_ready_out, 1'b1);
    exp_pkt++;
    for (int s = 0; s < 3; s++) exp_push(s, 14'h1234);
    @(posedge clk); #1;
    ca_valid_in = 1'b0;
    chk("t3_level0", lvl(0), 3'd1);
    chk("t3_level1", lvl(1), 3'd4);
    chk("t3_level2", lvl(2), 3'd1);
    chk("t3_pkt", pkt_count, 32'd10);
    ca_ready_in = 3'b111;
    cycles(6);
    chk("t3_drained", fifo_level, 9'd0);

    // T4: rank map r0->0 r1->1 r2->0 r3->3 (3 is out of range)
    beat(2'b10, 2'd0, 2'd0, 14'h0111, 1'b1, 3'b001, "t4_r0");
    beat(2'b10, 2'd0, 2'd1, 14'h0222, 1'b1, 3'b010, "t4_r1");
    beat(2'b10, 2'd0, 2'd2, 14'h0333, 1'b1, 3'b001, "t4_r2");
    beat(2'b10, 2'd0, 2'd3, 14'h0444, 1'b1, 3'b000, "t4_r3");
    chk("t4_err", err_count, 32'd1);
    chk("t4_pkt", pkt_count, 32'd14);
    beat(2'b01, 2'd3, 2'd0, 14'h0555, 1'b1, 3'b000, "uni_oob");
    routing_mode = 2'b11; ca_valid_in = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rsvd_ready", ca_ready_out, 1'b0);
      exp_err++;
      @(posedge clk); #1;
    end
    ca_valid_in = 1'b0;
    chk("rsvd_err", err_count, exp_err);
    chk("rsvd_pkt", pkt_count, exp_pkt);
    cycles(2);
    chk("t4_drained", fifo_level, 9'd0);

    // enable low: no accept, drain continues
    ca_ready_in = 3'b000;
    beat(2'b01, 2'd0, 2'd0, 14'h0666, 1'b1, 3'b001, "en_load");
    enable = 1'b0; ca_ready_in = 3'b001; ca_in = 14'h0777; ca_valid_in = 1'b1;
    @(negedge clk);
    chk("en_ready", ca_ready_out, 1'b0);
    @(posedge clk); #1;
    ca_valid_in = 1'b0;
    chk("en_drain", lvl(0), 3'd0);
    chk("en_pkt", pkt_count, 32'd16);
    enable = 1'b1; ca_ready_in = 3'b000;

    // T5: flush, then asynchronous reset mid-stream
    beat(2'b01, 2'd0, 2'd0, 14'h0A0A, 1'b1, 3'b001, "t5_b1");
    beat(2'b01, 2'd0, 2'd0, 14'h0B0B, 1'b1, 3'b001, "t5_b2");
    beat(2'b01, 2'd0, 2'd0, 14'h0C0C, 1'b1, 3'b001, "t5_b3");
    chk("t5_level0", lvl(0), 3'd3);
    flush = 1'b1; routing_mode = 2'b01; sc_select = 2'd1; ca_in = 14'h0DDD; ca_valid_in = 1'b1;
    @(negedge clk);
    chk("t5_flush_ready", ca_ready_out, 1'b0);
    @(posedge clk); #1;
    flush = 1'b0; ca_valid_in = 1'b0;
    q0.delete();
    chk("t5_flush_level", fifo_level, 9'd0);
    chk("t5_flush_valid", ca_valid_out, 3'b000);
    chk("t5_flush_pkt", pkt_count, 32'd19);
    beat(2'b01, 2'd1, 2'd0, 14'h0E0E, 1'b1, 3'b010, "t5_r1");
    beat(2'b01, 2'd1, 2'd0, 14'h0F0F, 1'b1, 3'b010, "t5_r2");
    chk("t5_level1", lvl(1), 3'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", ca_valid_out, 3'b000);
    chk("t5_rst_out", ca_out, 42'd0);
    chk("t5_rst_level", fifo_level, 9'd0);
    chk("t5_rst_pkt", pkt_count, 32'd0);
    chk("t5_rst_err", err_count, 32'd0);
    chk("t5_rst_ready", ca_ready_out, 1'b0);
    q0.delete(); q1.delete(); q2.delete();
    exp_pkt = 0; exp_err = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // T6: 3*FIFO_DEPTH broadcast beats so every pointer wraps
    ca_ready_in = 3'b111;
    for (int i = 0; i < 12; i++) begin
      d = 14'h0100 + 14'(i) * 14'h0123;
      beat(2'b00, 2'd0, 2'd0, d, 1'b1, 3'b111, "t6_wrap");
    end
    cycles(2);
    chk("t6_level", fifo_level, 9'd0);
    chk("t6_pkt", pkt_count, 32'd12);
    chk("q0_left", q0.size(), 0);
    chk("q1_left", q1.size(), 0);
    chk("q2_left", q2.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
